// File: rtl/corner_stream_mux.sv
// corner_stream_mux: merges NCH thresholded corner streams into one tagged word stream with per-frame trailers (c clk, r sync reset, en/min_score gate, fv/d/dv per channel in, q/qv/qrdy out, drop_cnt)
module corner_stream_mux #(
  parameter int NCH = 2,
  parameter int FIFO_AW = 4
) (
  input  logic              c,
  input  logic              r,
  input  logic              en,
  input  logic [7:0]        min_score,
  input  logic [NCH-1:0]    fv,
  input  logic [32*NCH-1:0] d,
  input  logic [NCH-1:0]    dv,
  output logic [31:0]       q,
  output logic              qv,
  input  logic              qrdy,
  output logic [15:0]       drop_cnt
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [FIFO_AW:0] LIM = (FIFO_AW+1)'(DEPTH - 2);
  logic [NCH-1:0][31:0] head;
  logic [NCH-1:0] ne, drop, pop;
  logic [PW-1:0] ptr, sel, idx;
  logic found, load;
  logic [16:0] dsum;
  assign load = ~qv | qrdy;
  assign dsum = {1'b0, drop_cnt} + 17'($countones(drop));
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [1:0] TAG = 2'(k);
    logic [31:0] mem [DEPTH];
    logic [FIFO_AW:0] wp, rp, occ;
    logic [15:0] cnt, cnt_n;
    logic fv_d, armed, in_frame, ovf, rise, fall, cand, wr, unused_hi;
    assign unused_hi = ^d[32*k+29 +: 3];
    assign occ = wp - rp;
    assign ne[k] = occ != '0;
    assign head[k] = mem[rp[FIFO_AW-1:0]];
    // armed blocks a false rising edge when reset releases in the middle of a frame
    assign rise = fv[k] & ~fv_d & armed;
    assign fall = ~fv[k] & fv_d & in_frame;
    assign cand = dv[k] & fv[k] & (in_frame | rise) & en & (d[32*k +: 8] >= min_score);
    // a corner needs two free slots so the trailer always has room
    assign wr = cand & (occ <= LIM);
    assign drop[k] = cand & ~wr;
    assign pop[k] = load & found & (sel == PW'(k));
    assign cnt_n = rise ? '0 : cnt;
    always_ff @(posedge c)
      if (wr | fall) mem[wp[FIFO_AW-1:0]] <= fall ? {1'b1, TAG, ovf, 12'h000, cnt} : {1'b0, TAG, d[32*k +: 29]};
    always_ff @(posedge c) begin
      if (r) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        fv_d <= 1'b0;
        armed <= 1'b0;
        in_frame <= 1'b0;
        ovf <= 1'b0;
      end else begin
        wp <= (wr | fall) ? wp + 1'b1 : wp;
        rp <= pop[k] ? rp + 1'b1 : rp;
        cnt <= cnt_n + {15'b0, wr & ~&cnt_n};
        fv_d <= fv[k];
        armed <= armed | ~fv[k];
        in_frame <= rise | (in_frame & ~fall);
        ovf <= (ovf & ~rise) | drop[k];
      end
    end
  end
  always_comb begin
    found = 1'b0;
    sel = ptr;
    idx = (ptr == PW'(NCH-1)) ? '0 : ptr + 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (!found && ne[idx]) begin
        found = 1'b1;
        sel = idx;
      end
      idx = (idx == PW'(NCH-1)) ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge c) begin
    if (r) begin
      q <= '0;
      qv <= 1'b0;
      ptr <= PW'(NCH-1);
      drop_cnt <= '0;
    end else begin
      drop_cnt <= dsum[16] ? 16'hFFFF : dsum[15:0];
      qv <= load ? found : qv;
      q <= (load & found) ? head[sel] : q;
      ptr <= (load & found) ? sel : ptr;
    end
  end
endmodule
